lvds_tx_link_trainer: RTL and testbench
=======================================

// Module: lvds_tx_link_trainer
// PURPOSE
//  Word-level transmit-side link controller feeding the lvds_tx serializer (tx_data) in the tx_clkdiv domain.
//  Emits the training pattern the far-end lvds_rx bit/word aligner locks on, waits for its aligned status,
//  sends one SYNC word, then streams user words via valid/ready, inserting IDLE words when no data is offered.
//  Retrains on request, on loss of far-end alignment, or on alignment timeout.
// PARAMETERS
//  DATA_WIDTH     8       word width; equals serializer factor
//  TRAIN_WORDS    64      minimum pattern words sent before alignment is checked (>=1)
//  ALIGN_TIMEOUT  4096    cycles in WAIT_ALIGN before a retry (>=1)
//  SYNC_WORD      8'hBC   single frame-start word sent after alignment
//  IDLE_WORD      8'h3C   filler word when no user data / disabled
// PORTS
//  clk         in   1           word clock (tx_clkdiv)
//  reset       in   1           asynchronous, active-low reset
//  enable      in   1           link enable; low forces IDLE
//  retrain     in   1           single-cycle pulse: restart training
//  pattern     in   DATA_WIDTH  training pattern (same value given to far-end lvds_rx)
//  rx_aligned  in   1           far-end alignment done; asynchronous, 2-flop synchronized inside
//  s_tdata     in   DATA_WIDTH  user word
//  s_tvalid    in   1           user word valid
//  s_tready    out  1           block accepts user word
//  tx_data     out  DATA_WIDTH  registered word to lvds_tx
//  link_up     out  1           high while in DATA
//  training    out  1           high in TRAIN or WAIT_ALIGN
//  retry_cnt   out  8           retrain count, saturates at 255
// BEHAVIOUR
//  - Reset (reset=0): state IDLE, tx_data=IDLE_WORD, s_tready=0, link_up=0, training=0, retry_cnt=0, sync flops 0.
//  - All outputs registered; tx_data reflects the state of the previous cycle (1-cycle latency).
//  - States: IDLE -> TRAIN -> WAIT_ALIGN -> SYNC -> DATA.
//    IDLE: tx_data<=IDLE_WORD; enable=1 -> TRAIN.
//    TRAIN: pattern captured into pattern_q on entry; tx_data<=pattern_q; word counter 0..TRAIN_WORDS-1, then WAIT_ALIGN.
//    WAIT_ALIGN: tx_data<=pattern_q; aligned_s=1 -> SYNC; timeout counter reaches ALIGN_TIMEOUT-1 -> TRAIN, retry_cnt+1.
//    SYNC: tx_data<=SYNC_WORD for exactly one cycle -> DATA.
//    DATA: s_tready=1; beat accepted when s_tvalid&&s_tready -> tx_data<=s_tdata next cycle, else IDLE_WORD.
//      aligned_s falls -> TRAIN, retry_cnt+1.
//  - s_tready = registered (state==DATA); a beat accepted in the last DATA cycle is still transmitted; never dropped.
//  - retrain=1 in any state except IDLE -> TRAIN next cycle, retry_cnt+1; counters cleared, pattern re-captured.
//  - Priority: enable=0 > retrain > aligned_s loss/timeout > normal transitions.
//  - enable=0 in any state -> IDLE next cycle, counters cleared, retry_cnt held.
//  - retrain coincident with aligned_s loss or timeout: one increment only.
//  - retry_cnt saturates at 8'hFF; cleared only by reset.
//  - rx_aligned uses 2 synchronizer flops: 2-3 cycle detection latency; aligned_s must already be 0 for
//    WAIT_ALIGN to wait, stale 1 from a previous link is accepted (far end keeps it low while misaligned).
//  - Counters sized $clog2 of their limits; no wrap beyond limit (reset on state change).
// STRUCTURE
//  - Package lvds_pkg: state encoding constants (ST_IDLE..ST_DATA), default SYNC_WORD/IDLE_WORD.
//  - One sub-module: lvds_sync_bit (2-flop synchronizer, async active-low reset), reused for rx_aligned.
//  - Single FSM process + registered output process; no other hierarchy.
// TESTING
//  1. reset=0 then release, enable=1, pattern=8'hA5 -> tx_data IDLE_WORD, then 64 words 8'hA5, training=1.
//  2. rx_aligned=1 during WAIT_ALIGN -> pattern continues 2-3 cycles, one 8'hBC, then link_up=1, s_tready=1.
//  3. DATA, s_tvalid=1 with 8'h01,02,03, gap, 8'h04 -> tx_data 01,02,03,3C,04 each 1 cycle after acceptance.
//  4. rx_aligned held 0 -> after 64+4096 cycles return to TRAIN, retry_cnt=1; 300 timeouts -> retry_cnt=255.
//  5. DATA with s_tvalid=1 8'h77, retrain pulse same cycle -> 8'h77 sent, then pattern, retry_cnt +1 only once.
//  6. reset asserted mid-DATA -> all outputs at reset values immediately (async), tx_data=8'h3C.

Source files
------------

// File: rtl/lvds_tx_link_trainer_pkg.sv
// Shared types and defaults for the LVDS transmit link trainer.
// State encoding, default control words and counter sizing helper.
package lvds_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_TRAIN      = 3'd1,
        ST_WAIT_ALIGN = 3'd2,
        ST_SYNC       = 3'd3,
        ST_DATA       = 3'd4
    } state_e;

    localparam logic [7:0] DEF_SYNC_WORD = 8'hBC;
    localparam logic [7:0] DEF_IDLE_WORD = 8'h3C;

    localparam logic [7:0] RETRY_MAX = 8'hFF;

    // Width of a counter that runs 0..limit-1; never narrower than 1 bit.
    function automatic int cnt_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/lvds_tx_link_trainer_if.sv
// User word stream into the link trainer.
// Valid/ready handshake; a beat moves when tvalid and tready are both high.
interface lvds_tx_link_trainer_if #(
    parameter int DATA_WIDTH = 8
);

    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );

endinterface

// File: rtl/lvds_tx_link_trainer_sync_bit.sv
// Two-flop synchronizer for a single asynchronous level.
// Both flops clear to 0 on reset.
module lvds_sync_bit (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/lvds_tx_link_trainer.sv
// Transmit-side link trainer: training pattern, alignment wait, SYNC word,
// then user words with IDLE fill; retrains on request, alignment loss or timeout.
module lvds_tx_link_trainer
    import lvds_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 8,
    parameter int                    TRAIN_WORDS   = 64,
    parameter int                    ALIGN_TIMEOUT = 4096,
    parameter logic [DATA_WIDTH-1:0] SYNC_WORD     = DATA_WIDTH'(DEF_SYNC_WORD),
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD     = DATA_WIDTH'(DEF_IDLE_WORD)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  retrain,
    input  logic [DATA_WIDTH-1:0] pattern,
    input  logic                  rx_aligned,
    lvds_tx_link_trainer_if.slave s,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  link_up,
    output logic                  training,
    output logic [7:0]            retry_cnt
);

    localparam int TW = cnt_width(TRAIN_WORDS);
    localparam int AW = cnt_width(ALIGN_TIMEOUT);

    localparam logic [TW-1:0] TRAIN_LAST = TW'(TRAIN_WORDS - 1);
    localparam logic [AW-1:0] TMO_LAST   = AW'(ALIGN_TIMEOUT - 1);

    state_e                state;
    state_e                nxt;
    logic [TW-1:0]         train_cnt;
    logic [AW-1:0]         tmo_cnt;
    logic [DATA_WIDTH-1:0] pattern_q;
    logic                  aligned_s;
    logic                  timeout;
    logic                  loss;
    logic                  restart;
    logic                  beat;

    lvds_sync_bit u_sync (
        .clk   (clk),
        .rst_n (reset),
        .d     (rx_aligned),
        .q     (aligned_s)
    );

    assign timeout = (state == ST_WAIT_ALIGN) && (tmo_cnt == TMO_LAST);
    assign loss    = (state == ST_DATA) && !aligned_s;
    assign beat    = s.tvalid && s.tready;

    // Retrain, loss and timeout collapse into one restart: a single retry bump.
    assign restart = enable && (state != ST_IDLE) &&
                     (retrain || loss || timeout);

    always_comb begin
        nxt = state;
        if (!enable) begin
            nxt = ST_IDLE;
        end else if (restart) begin
            nxt = ST_TRAIN;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    nxt = ST_TRAIN;
                end
                ST_TRAIN: begin
                    if (train_cnt == TRAIN_LAST) begin
                        nxt = ST_WAIT_ALIGN;
                    end
                end
                ST_WAIT_ALIGN: begin
                    if (aligned_s) begin
                        nxt = ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    nxt = ST_DATA;
                end
                ST_DATA: begin
                    nxt = ST_DATA;
                end
                default: begin
                    nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            train_cnt <= '0;
            tmo_cnt   <= '0;
            pattern_q <= '0;
            retry_cnt <= '0;
        end else begin
            state <= nxt;

            if (nxt == ST_TRAIN && (state != ST_TRAIN || restart)) begin
                pattern_q <= pattern;
            end

            // Counters only run while their state is held; any change clears them.
            if (nxt != state || restart) begin
                train_cnt <= '0;
                tmo_cnt   <= '0;
            end else begin
                if (state == ST_TRAIN) begin
                    train_cnt <= train_cnt + 1'b1;
                end
                if (state == ST_WAIT_ALIGN) begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end

            if (restart && retry_cnt != RETRY_MAX) begin
                retry_cnt <= retry_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_data  <= IDLE_WORD;
            s.tready <= 1'b0;
            link_up  <= 1'b0;
            training <= 1'b0;
        end else begin
            s.tready <= (nxt == ST_DATA);
            link_up  <= (nxt == ST_DATA);
            training <= (nxt == ST_TRAIN) || (nxt == ST_WAIT_ALIGN);

            // A beat accepted in the final DATA cycle still goes out.
            unique case (state)
                ST_TRAIN, ST_WAIT_ALIGN: begin
                    tx_data <= pattern_q;
                end
                ST_SYNC: begin
                    tx_data <= SYNC_WORD;
                end
                ST_DATA: begin
                    tx_data <= beat ? s.tdata : IDLE_WORD;
                end
                default: begin
                    tx_data <= IDLE_WORD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lvds_tx_link_trainer.sv
// Directed plus randomized checks of the LVDS transmit link trainer.
// Expected words come from the link rules and a queue of accepted beats.
module tb_lvds_tx_link_trainer;

    localparam int         DW    = 8;
    localparam int         TW    = 8;
    localparam int         AT    = 32;
    localparam logic [7:0] SYNCW = 8'hBC;
    localparam logic [7:0] IDLEW = 8'h3C;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       retrain;
    logic [7:0] pattern;
    logic       rx_aligned;
    logic [7:0] tx_data;
    logic       link_up;
    logic       training;
    logic [7:0] retry_cnt;

    int total = 0;
    int bad   = 0;
    int exp_retry = 0;
    logic [7:0] sent_q[$];

    lvds_tx_link_trainer_if #(.DATA_WIDTH(DW)) s_if ();

    lvds_tx_link_trainer #(
        .DATA_WIDTH    (DW),
        .TRAIN_WORDS   (TW),
        .ALIGN_TIMEOUT (AT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .retrain    (retrain),
        .pattern    (pattern),
        .rx_aligned (rx_aligned),
        .s          (s_if),
        .tx_data    (tx_data),
        .link_up    (link_up),
        .training   (training),
        .retry_cnt  (retry_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bump_retry();
        exp_retry = (exp_retry < 255) ? exp_retry + 1 : 255;
    endtask

    task automatic wait_link(input string tag, input int bound);
        int n = 0;
        while (link_up !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, link_up}, 32'd1);
    endtask

    // Random offers while up: every accepted word appears exactly one cycle later.
    task automatic data_burst(input string tag, input int n);
        logic       v;
        logic [7:0] d;
        logic [7:0] e;
        for (int i = 0; i < n; i++) begin
            v = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            s_if.tvalid = v;
            s_if.tdata  = d;
            if (v) sent_q.push_back(d);
            tick();
            e = (v && sent_q.size() > 0) ? sent_q.pop_front() : IDLEW;
            chk(tag, {24'd0, tx_data}, {24'd0, e});
        end
        s_if.tvalid = 1'b0;
        chk({tag, "_ready"}, {31'd0, s_if.tready}, 32'd1);
    endtask

    initial begin
        logic [7:0] vals[5];
        logic       vlds[5];
        logic [7:0] p2;
        int         n;

        reset       = 1'b0;
        enable      = 1'b1;
        retrain     = 1'b0;
        pattern     = 8'hA5;
        rx_aligned  = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;

        #21;
        chk("rst_tx",    {24'd0, tx_data},   {24'd0, IDLEW});
        chk("rst_ready", {31'd0, s_if.tready}, 32'd0);
        chk("rst_link",  {31'd0, link_up},   32'd0);
        chk("rst_train", {31'd0, training},  32'd0);
        chk("rst_retry", {24'd0, retry_cnt}, 32'd0);
        #1 reset = 1'b1;

        tick();
        chk("first_idle",  {24'd0, tx_data},  {24'd0, IDLEW});
        chk("first_train", {31'd0, training}, 32'd1);
        for (int i = 0; i < TW; i++) begin
            tick();
            chk("train_word", {24'd0, tx_data}, 32'h0000_00A5);
        end
        chk("train_flag", {31'd0, training}, 32'd1);
        chk("train_link", {31'd0, link_up},  32'd0);

        rx_aligned = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (tx_data !== 8'hA5) break;
            n++;
        end
        chk("align_lat",  {31'd0, (n >= 2 && n <= 3)}, 32'd1);
        chk("sync_word",  {24'd0, tx_data}, {24'd0, SYNCW});
        tick();
        chk("up_link",  {31'd0, link_up},     32'd1);
        chk("up_ready", {31'd0, s_if.tready}, 32'd1);
        chk("up_idle",  {24'd0, tx_data},     {24'd0, IDLEW});
        chk("up_train", {31'd0, training},    32'd0);

        vals = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h04};
        vlds = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            s_if.tvalid = vlds[i];
            s_if.tdata  = vals[i];
            tick();
            chk("seq_word", {24'd0, tx_data},
                {24'd0, vlds[i] ? vals[i] : IDLEW});
        end
        s_if.tvalid = 1'b0;

        data_burst("rand_a", 60);

        p2 = 8'($urandom);
        pattern     = p2;
        s_if.tvalid = 1'b1;
        s_if.tdata  = 8'h77;
        retrain     = 1'b1;
        tick();
        bump_retry();
        retrain     = 1'b0;
        s_if.tvalid = 1'b0;
        chk("rt_last",  {24'd0, tx_data},     32'h0000_0077);
        chk("rt_train", {31'd0, training},    32'd1);
        chk("rt_ready", {31'd0, s_if.tready}, 32'd0);
        chk("rt_retry", {24'd0, retry_cnt},   exp_retry);
        tick();
        chk("rt_pat",   {24'd0, tx_data},     {24'd0, p2});
        wait_link("rt_relink", TW + 20);
        chk("rt_once",  {24'd0, retry_cnt},   exp_retry);

        rx_aligned = 1'b0;
        tick();
        tick();
        retrain = 1'b1;
        tick();
        bump_retry();
        retrain = 1'b0;
        chk("loss_train", {31'd0, training},  32'd1);
        chk("loss_link",  {31'd0, link_up},   32'd0);
        chk("loss_once",  {24'd0, retry_cnt}, exp_retry);

        for (int k = 0; k < 2; k++) begin
            repeat (TW + AT - 1) tick();
            chk("tmo_hold",  {24'd0, retry_cnt}, exp_retry);
            chk("tmo_pat",   {24'd0, tx_data},   {24'd0, p2});
            chk("tmo_flag",  {31'd0, training},  32'd1);
            tick();
            bump_retry();
            chk("tmo_bump",  {24'd0, retry_cnt}, exp_retry);
        end

        repeat (300 * (TW + AT)) tick();
        for (int k = 0; k < 300; k++) bump_retry();
        chk("retry_sat", {24'd0, retry_cnt}, exp_retry);

        enable = 1'b0;
        tick();
        chk("dis_train", {31'd0, training}, 32'd0);
        tick();
        chk("dis_tx",    {24'd0, tx_data},   {24'd0, IDLEW});
        chk("dis_retry", {24'd0, retry_cnt}, exp_retry);
        retrain = 1'b1;
        tick();
        retrain = 1'b0;
        tick();
        chk("idle_rt_flag",  {31'd0, training},  32'd0);
        chk("idle_rt_retry", {24'd0, retry_cnt}, exp_retry);

        rx_aligned = 1'b1;
        enable     = 1'b1;
        wait_link("reen_link", TW + 20);
        chk("reen_sync", {24'd0, tx_data}, {24'd0, SYNCW});
        data_burst("rand_b", 40);

        #3 reset = 1'b0;
        #1;
        chk("arst_tx",    {24'd0, tx_data},     {24'd0, IDLEW});
        chk("arst_ready", {31'd0, s_if.tready}, 32'd0);
        chk("arst_link",  {31'd0, link_up},     32'd0);
        chk("arst_train", {31'd0, training},    32'd0);
        chk("arst_retry", {24'd0, retry_cnt},   32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
